// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller, plus the address-bus macros.
// The optional stall watchdog in pipeline_ctrl is enabled with PIPE_STALL_WATCHDOG_EN.
`ifndef PIPELINE_DEFINES
`define PIPELINE_DEFINES
`define AddressBus 31:0
`define ZeroWord 32'h00000000
`endif

package pipeline_ctrl_pkg;
  localparam logic [5:0] StallNone   = 6'b000000;
  localparam logic [5:0] StallFromId = 6'b000111;
  localparam logic [5:0] StallFromEx = 6'b001111;

  localparam int StallCntW = 32;
  localparam int FlushCntW = 16;
  localparam int SettleW   = 4;
  localparam int WdCntW    = 32;

  typedef enum logic {RUN = 1'b0, SETTLE = 1'b1} state_t;
endpackage

// File: rtl/pipeline_ctrl.sv
// Stall/flush arbiter for the 6-stage pipeline with post-flush settle window and perf counters.
// Define PIPE_STALL_WATCHDOG_EN to build the consecutive-stall watchdog (stall_timeout).
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1,
  parameter int WATCHDOG_LIMIT = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stallreq_from_id,
  input  logic                 stallreq_from_ex,
  input  logic                 flush_req,
  input  logic [`AddressBus]   flush_pc,
  input  logic                 counter_clear,
  output logic [5:0]           stall,
  output logic                 flush,
  output logic [`AddressBus]   new_pc,
  output logic [StallCntW-1:0] stall_cycles,
  output logic [FlushCntW-1:0] flush_count,
  output logic                 stall_timeout
);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES);

  state_t             state;
  logic [SettleW-1:0] settle_cnt;

  // Outputs are forced quiet while reset is held so downstream registers see no request.
  always_comb begin
    stall  = StallNone;
    flush  = 1'b0;
    new_pc = `ZeroWord;
    if (reset) begin
      if (flush_req) begin
        flush  = 1'b1;
        new_pc = flush_pc;
      end else if (state == RUN) begin
        if (stallreq_from_ex)      stall = StallFromEx;
        else if (stallreq_from_id) stall = StallFromId;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      settle_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (flush_req) begin
            state      <= SETTLE;
            settle_cnt <= SettleLoad;
          end
        end
        SETTLE: begin
          if (flush_req) begin
            settle_cnt <= SettleLoad;
          end else if (settle_cnt <= 1) begin
            state      <= RUN;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: begin
          state      <= RUN;
          settle_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (counter_clear) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall != StallNone && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (flush && flush_count != '1)               flush_count  <= flush_count + 1'b1;
    end
  end

`ifdef PIPE_STALL_WATCHDOG_EN
  logic [WdCntW-1:0] wd_cnt;
  logic [WdCntW-1:0] wd_nxt;

  assign wd_nxt = (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else if (counter_clear) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else if (stall != StallNone) begin
      wd_cnt <= wd_nxt;
      if (wd_nxt >= WdCntW'(WATCHDOG_LIMIT)) stall_timeout <= 1'b1;
    end else begin
      // flush cycles always carry stall==0, so this also covers the flush clear
      wd_cnt <= '0;
    end
  end
`else
  localparam int unused_wd_limit = WATCHDOG_LIMIT;
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl; two instances (settle 1 and 3) share stimulus.
module tb_pipeline_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stallreq_from_id = 1'b0, stallreq_from_ex = 1'b0, flush_req = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        counter_clear = 1'b0;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b;
  logic [31:0] new_pc_a, new_pc_b;
  logic [31:0] sc_a, sc_b;
  logic [15:0] fc_a, fc_b;
  logic        to_a, to_b;

  localparam int WdLimit = 8;

  pipeline_ctrl #(.SETTLE_CYCLES(1), .WATCHDOG_LIMIT(WdLimit)) u_dut_s1 (
    .clock(clock), .reset(reset), .stallreq_from_id(stallreq_from_id),
    .stallreq_from_ex(stallreq_from_ex), .flush_req(flush_req), .flush_pc(flush_pc),
    .counter_clear(counter_clear), .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a),
    .stall_cycles(sc_a), .flush_count(fc_a), .stall_timeout(to_a));

  pipeline_ctrl #(.SETTLE_CYCLES(3), .WATCHDOG_LIMIT(WdLimit)) u_dut_s3 (
    .clock(clock), .reset(reset), .stallreq_from_id(stallreq_from_id),
    .stallreq_from_ex(stallreq_from_ex), .flush_req(flush_req), .flush_pc(flush_pc),
    .counter_clear(counter_clear), .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b),
    .stall_cycles(sc_b), .flush_count(fc_b), .stall_timeout(to_b));

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycle-indexed view of the flush history rather than an FSM.
  int          cyc;
  int          last_fl [2];
  longint      sc_m    [2];
  int          fc_m    [2];
  int          run_m   [2];
  bit          to_m    [2];
  int          settle  [2] = '{1, 3};

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      last_fl[i] = -100; sc_m[i] = 0; fc_m[i] = 0; run_m[i] = 0; to_m[i] = 0;
    end
  endtask

  task automatic step(input bit id, input bit ex, input bit fl, input logic [31:0] pc, input bit clr);
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [5:0]  g_stall;
    logic        g_flush, g_to;
    logic [31:0] g_pc, g_sc, g_fc;
    stallreq_from_id = id; stallreq_from_ex = ex; flush_req = fl;
    flush_pc = pc; counter_clear = clr;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      e_stall = 6'd0; e_flush = 1'b0; e_pc = 32'h0;
      if (fl) begin
        e_flush = 1'b1; e_pc = pc;
      end else if (cyc - last_fl[i] > settle[i]) begin
        if (ex)      e_stall = 6'b001111;
        else if (id) e_stall = 6'b000111;
      end
      g_stall = (i == 0) ? stall_a  : stall_b;
      g_flush = (i == 0) ? flush_a  : flush_b;
      g_pc    = (i == 0) ? new_pc_a : new_pc_b;
      g_sc    = (i == 0) ? sc_a : sc_b;
      g_fc    = (i == 0) ? {16'h0, fc_a} : {16'h0, fc_b};
      g_to    = (i == 0) ? to_a : to_b;
      chk($sformatf("stall[%0d]", i),  {26'h0, g_stall}, {26'h0, e_stall});
      chk($sformatf("flush[%0d]", i),  {31'h0, g_flush}, {31'h0, e_flush});
      chk($sformatf("new_pc[%0d]", i), g_pc, e_pc);
      chk($sformatf("stall_cycles[%0d]", i), g_sc, sc_m[i][31:0]);
      chk($sformatf("flush_count[%0d]", i),  g_fc, fc_m[i]);
`ifdef PIPE_STALL_WATCHDOG_EN
      chk($sformatf("timeout[%0d]", i), {31'h0, g_to}, {31'h0, to_m[i]});
`else
      chk($sformatf("timeout[%0d]", i), {31'h0, g_to}, 32'h0);
`endif
      // advance model across the coming edge
      if (fl) last_fl[i] = cyc;
      if (clr) begin
        sc_m[i] = 0; fc_m[i] = 0; run_m[i] = 0; to_m[i] = 0;
      end else begin
        if (e_stall != 0 && sc_m[i] < 64'hFFFF_FFFF) sc_m[i]++;
        if (e_flush && fc_m[i] < 16'hFFFF) fc_m[i]++;
        if (e_stall != 0) begin
          run_m[i]++;
          if (run_m[i] >= WdLimit) to_m[i] = 1;
        end else run_m[i] = 0;
      end
    end
    cyc++;
    @(posedge clock); #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_stall", {26'h0, stall_a}, 32'h0);
    chk("rst_flush", {31'h0, flush_b}, 32'h0);
    chk("rst_sc",    sc_a, 32'h0);
    chk("rst_fc",    {16'h0, fc_b}, 32'h0);
    reset = 1'b1;
    model_reset();

    step(0, 0, 0, 32'h0, 0);
    // ID stall for three cycles
    for (int k = 0; k < 3; k++) step(1, 0, 0, 32'h0, 0);
    chk("id3_sc", sc_a, 32'd3);
    step(1, 1, 0, 32'h0, 0);
    // flush while EX stalls, settle 1 vs settle 3
    step(0, 0, 0, 32'h0, 1);
    step(0, 1, 1, 32'h140, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    chk("fl1_fc", {16'h0, fc_a}, 32'd1);
    // second flush inside the settle window of the 3-cycle instance
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h200, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 1, 32'h300, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 32'h0, 0);
    chk("fl2_fc", {16'h0, fc_b}, 32'd2);
    // watchdog: 8 consecutive EX stalls
    step(0, 0, 0, 32'h0, 1);
    for (int k = 0; k < WdLimit; k++) step(0, 1, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
`ifdef PIPE_STALL_WATCHDOG_EN
    chk("wd_sticky", {31'h0, to_a}, 32'h1);
`endif
    step(0, 0, 0, 32'h0, 1);
    chk("clr_sc", sc_a, 32'h0);
    chk("clr_to", {31'h0, to_a}, 32'h0);

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
           $urandom, $urandom_range(0, 39) == 0);

    // asynchronous reset in the middle of traffic
    stallreq_from_ex = 1'b1; stallreq_from_id = 1'b1; flush_req = 1'b0; counter_clear = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_stall_a", {26'h0, stall_a}, 32'h0);
    chk("arst_stall_b", {26'h0, stall_b}, 32'h0);
    chk("arst_sc",      sc_b, 32'h0);
    chk("arst_fc",      {16'h0, fc_a}, 32'h0);
    chk("arst_to",      {31'h0, to_a}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    step(0, 0, 0, 32'h0, 0);
    for (int k = 0; k < 100; k++)
      step($urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
           $urandom, $urandom_range(0, 49) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
